// File: rtl/parse_drop_filter.sv
// parse_drop_filter: forwards or drops whole AXI-Stream packets on a
// per-packet parse verdict, through a registered main/skid output stage.
module parse_drop_filter #(
    parameter int AXIS_BUS_WIDTH  = 64,
    parameter int SIDE_CHAN_WIDTH = 10,
    parameter int CNT_WIDTH       = 32,
    parameter int NUM_BUS_BYTES   = AXIS_BUS_WIDTH / 8
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [AXIS_BUS_WIDTH-1:0]  axis_in_tdata,
    input  logic [NUM_BUS_BYTES-1:0]   axis_in_tkeep,
    input  logic                       axis_in_tlast,
    input  logic                       axis_in_tvalid,
    output logic                       axis_in_tready,
    input  logic [SIDE_CHAN_WIDTH-1:0] chan_in_data,
    input  logic                       chan_in_error,
    output logic [AXIS_BUS_WIDTH-1:0]  axis_out_tdata,
    output logic [NUM_BUS_BYTES-1:0]   axis_out_tkeep,
    output logic                       axis_out_tlast,
    output logic [SIDE_CHAN_WIDTH-1:0] axis_out_tuser,
    output logic                       axis_out_tvalid,
    input  logic                       axis_out_tready,
    input  logic                       clear_counts,
    output logic [CNT_WIDTH-1:0]       pass_count,
    output logic [CNT_WIDTH-1:0]       drop_count
);

    typedef enum logic [1:0] {
        SOP,
        PASS,
        DROP
    } state_t;

    typedef struct packed {
        logic [AXIS_BUS_WIDTH-1:0]  data;
        logic [NUM_BUS_BYTES-1:0]   keep;
        logic                       last;
        logic [SIDE_CHAN_WIDTH-1:0] user;
    } beat_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE =
        {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                     state_q, state_d;
    logic [SIDE_CHAN_WIDTH-1:0] tuser_q, tuser_d;
    logic [SIDE_CHAN_WIDTH-1:0] beat_user;
    beat_t                      main_q, main_d;
    beat_t                      skid_q, skid_d;
    beat_t                      beat_in;
    logic                       main_valid_q, main_valid_d;
    logic                       skid_valid_q, skid_valid_d;
    logic [CNT_WIDTH-1:0]       pass_q, pass_d;
    logic [CNT_WIDTH-1:0]       drop_q, drop_d;
    logic                       in_ready;
    logic                       accept;
    logic                       fwd;
    logic                       discard;
    logic                       out_take;

    // Input ready: registered skid status only; always open while dropping
    always_comb begin
        in_ready = aresetn && (state_q == DROP || !skid_valid_q);
        accept   = axis_in_tvalid && in_ready;
    end

    // Packet FSM: verdict is sampled on the first beat only
    always_comb begin
        state_d   = state_q;
        tuser_d   = tuser_q;
        beat_user = tuser_q;
        fwd       = 1'b0;
        discard   = 1'b0;
        unique case (state_q)
            SOP: begin
                if (accept) begin
                    if (chan_in_error) begin
                        discard = 1'b1;
                        state_d = axis_in_tlast ? SOP : DROP;
                    end else begin
                        fwd       = 1'b1;
                        beat_user = chan_in_data;
                        tuser_d   = chan_in_data;
                        state_d   = axis_in_tlast ? SOP : PASS;
                    end
                end
            end
            PASS: begin
                if (accept) begin
                    fwd = 1'b1;
                    if (axis_in_tlast) state_d = SOP;
                end
            end
            DROP: begin
                if (accept) begin
                    discard = 1'b1;
                    if (axis_in_tlast) state_d = SOP;
                end
            end
            default: state_d = SOP;
        endcase
    end

    // Main/skid stage: skid refills main as soon as downstream takes main
    always_comb begin
        beat_in      = '{data: axis_in_tdata, keep: axis_in_tkeep,
                         last: axis_in_tlast, user: beat_user};
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        out_take     = main_valid_q && axis_out_tready;
        if (out_take) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                main_d       = beat_in;
                main_valid_d = fwd;
            end
        end else if (!main_valid_q) begin
            main_d       = beat_in;
            main_valid_d = fwd;
        end else if (fwd) begin
            skid_d       = beat_in;
            skid_valid_d = 1'b1;
        end
    end

    // Saturating packet counters; clear has priority over increment
    always_comb begin
        pass_d = pass_q;
        drop_d = drop_q;
        if (clear_counts) begin
            pass_d = '0;
            drop_d = '0;
        end else begin
            if (fwd && axis_in_tlast && pass_q != '1)
                pass_d = pass_q + CNT_ONE;
            if (discard && axis_in_tlast && drop_q != '1)
                drop_d = drop_q + CNT_ONE;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= SOP;
            tuser_q      <= '0;
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            pass_q       <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            tuser_q      <= tuser_d;
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            pass_q       <= pass_d;
            drop_q       <= drop_d;
        end
    end

    assign axis_in_tready  = in_ready;
    assign axis_out_tdata  = main_q.data;
    assign axis_out_tkeep  = main_q.keep;
    assign axis_out_tlast  = main_q.last;
    assign axis_out_tuser  = main_q.user;
    assign axis_out_tvalid = main_valid_q;
    assign pass_count      = pass_q;
    assign drop_count      = drop_q;

endmodule

// File: tb/tb_parse_drop_filter.sv
// tb_parse_drop_filter: directed bench for parse_drop_filter
// (4-bit counters so saturation is reachable quickly).
module tb_parse_drop_filter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [63:0] in_tdata;
    logic [7:0]  in_tkeep;
    logic        in_tlast;
    logic        in_tvalid;
    logic        in_tready;
    logic [9:0]  chan_data;
    logic        chan_err;
    logic [63:0] out_tdata;
    logic [7:0]  out_tkeep;
    logic        out_tlast;
    logic [9:0]  out_tuser;
    logic        out_tvalid;
    logic        out_tready;
    logic        clear;
    logic [3:0]  pass_cnt;
    logic [3:0]  drop_cnt;

    int total = 0;
    int fails = 0;

    parse_drop_filter #(
        .AXIS_BUS_WIDTH (64),
        .SIDE_CHAN_WIDTH(10),
        .CNT_WIDTH      (4)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .axis_in_tdata  (in_tdata),
        .axis_in_tkeep  (in_tkeep),
        .axis_in_tlast  (in_tlast),
        .axis_in_tvalid (in_tvalid),
        .axis_in_tready (in_tready),
        .chan_in_data   (chan_data),
        .chan_in_error  (chan_err),
        .axis_out_tdata (out_tdata),
        .axis_out_tkeep (out_tkeep),
        .axis_out_tlast (out_tlast),
        .axis_out_tuser (out_tuser),
        .axis_out_tvalid(out_tvalid),
        .axis_out_tready(out_tready),
        .clear_counts   (clear),
        .pass_count     (pass_cnt),
        .drop_count     (drop_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic beat(input logic [63:0] d, input logic last,
                        input logic err, input logic [9:0] ch,
                        input logic [7:0] keep);
        in_tvalid = 1'b1;
        in_tdata  = d;
        in_tlast  = last;
        chan_err  = err;
        chan_data = ch;
        in_tkeep  = keep;
    endtask

    task automatic out_is(input string tag, input logic [63:0] d,
                          input logic last, input logic [9:0] u);
        chk({tag, "_valid"}, out_tvalid, 1'b1);
        chk({tag, "_data"}, out_tdata, d);
        chk({tag, "_last"}, out_tlast, last);
        chk({tag, "_user"}, out_tuser, u);
    endtask

    initial begin
        logic [63:0] got[$];
        int nin;
        int nout;
        int idx;

        aresetn    = 1'b0;
        in_tvalid  = 1'b0;
        in_tdata   = '0;
        in_tkeep   = '0;
        in_tlast   = 1'b0;
        chan_data  = '0;
        chan_err   = 1'b0;
        out_tready = 1'b1;
        clear      = 1'b0;

        // reset state
        repeat (3) step();
        chk("rst_ovalid", out_tvalid, 1'b0);
        chk("rst_iready", in_tready, 1'b0);
        chk("rst_pass", pass_cnt, 4'd0);
        chk("rst_drop", drop_cnt, 4'd0);
        chk("rst_user", out_tuser, 10'h000);
        aresetn = 1'b1;
        #1;
        chk("post_rst_iready", in_tready, 1'b1);

        // 3-beat pass packet, tkeep=0 on beat 2
        beat(64'hA1, 1'b0, 1'b0, 10'h155, 8'hFF);
        step();
        out_is("p3b1", 64'hA1, 1'b0, 10'h155);
        beat(64'hA2, 1'b0, 1'b0, 10'h155, 8'h00);
        step();
        out_is("p3b2", 64'hA2, 1'b0, 10'h155);
        chk("p3b2_keep", out_tkeep, 8'h00);
        beat(64'hA3, 1'b1, 1'b0, 10'h155, 8'hFF);
        step();
        out_is("p3b3", 64'hA3, 1'b1, 10'h155);
        chk("p3_pass", pass_cnt, 4'd1);
        in_tvalid = 1'b0;
        step();
        chk("p3_idle", out_tvalid, 1'b0);

        // dropped 2-beat packet, then 1-beat pass packet
        beat(64'hB1, 1'b0, 1'b1, 10'h3FF, 8'hFF);
        step();
        chk("drop_b1_ovalid", out_tvalid, 1'b0);
        chk("drop_b1_iready", in_tready, 1'b1);
        beat(64'hB2, 1'b1, 1'b1, 10'h3FF, 8'hFF);
        step();
        chk("drop_b2_ovalid", out_tvalid, 1'b0);
        chk("drop_cnt1", drop_cnt, 4'd1);
        beat(64'hE1, 1'b1, 1'b0, 10'h0A0, 8'hFF);
        step();
        out_is("one_beat", 64'hE1, 1'b1, 10'h0A0);
        chk("one_beat_pass", pass_cnt, 4'd2);
        chk("one_beat_drop", drop_cnt, 4'd1);
        in_tvalid = 1'b0;
        step();

        // verdict changes after first beat are ignored
        beat(64'hF1, 1'b0, 1'b0, 10'h123, 8'hFF);
        step();
        out_is("late_b1", 64'hF1, 1'b0, 10'h123);
        beat(64'hF2, 1'b0, 1'b1, 10'h2AA, 8'hFF);
        step();
        out_is("late_b2", 64'hF2, 1'b0, 10'h123);
        beat(64'hF3, 1'b0, 1'b1, 10'h2AA, 8'hFF);
        step();
        out_is("late_b3", 64'hF3, 1'b0, 10'h123);
        beat(64'hF4, 1'b1, 1'b1, 10'h2AA, 8'hFF);
        step();
        out_is("late_b4", 64'hF4, 1'b1, 10'h123);
        chk("late_pass", pass_cnt, 4'd3);
        chk("late_drop", drop_cnt, 4'd1);
        in_tvalid = 1'b0;
        step();

        // 20 beats with downstream ready toggling every cycle
        nin  = 0;
        nout = 0;
        idx  = 0;
        for (int cyc = 0; cyc < 200 && nout < 20; cyc++) begin
            if (idx < 20)
                beat(64'hC000 + 64'(idx), idx == 19, 1'b0,
                     10'h077, 8'hFF);
            else
                in_tvalid = 1'b0;
            out_tready = (cyc % 2) == 0;
            @(negedge aclk);
            chk("bp_iready", in_tready, (nin - nout) < 2);
            if (out_tvalid && out_tready) begin
                got.push_back(out_tdata);
                chk("bp_user", out_tuser, 10'h077);
                nout++;
            end
            if (in_tvalid && in_tready) begin
                nin++;
                idx++;
            end
            step();
        end
        in_tvalid  = 1'b0;
        out_tready = 1'b1;
        chk("bp_count", 64'(got.size()), 64'd20);
        for (int i = 0; i < got.size(); i++)
            chk("bp_order", got[i], 64'hC000 + 64'(i));
        chk("bp_pass", pass_cnt, 4'd4);
        step();
        chk("bp_idle", out_tvalid, 1'b0);

        // reset in the middle of a pass packet
        beat(64'h71, 1'b0, 1'b0, 10'h111, 8'hFF);
        step();
        out_is("mid_b1", 64'h71, 1'b0, 10'h111);
        beat(64'h72, 1'b0, 1'b0, 10'h111, 8'hFF);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_iready", in_tready, 1'b0);
        step();
        chk("mid_rst_ovalid", out_tvalid, 1'b0);
        chk("mid_rst_pass", pass_cnt, 4'd0);
        aresetn = 1'b1;
        beat(64'h73, 1'b1, 1'b1, 10'h111, 8'hFF);
        step();
        chk("mid_sop_drop_ov", out_tvalid, 1'b0);
        chk("mid_sop_drop", drop_cnt, 4'd1);
        beat(64'h74, 1'b1, 1'b0, 10'h0F0, 8'hFF);
        step();
        out_is("mid_next", 64'h74, 1'b1, 10'h0F0);
        chk("mid_pass", pass_cnt, 4'd1);

        // saturation: 17 more single-beat packets -> 18 saturates at 15
        for (int i = 0; i < 17; i++) begin
            beat(64'hD00 + 64'(i), 1'b1, 1'b0, 10'h005, 8'hFF);
            step();
        end
        in_tvalid = 1'b0;
        chk("sat_pass", pass_cnt, 4'd15);
        chk("sat_last_out", out_tdata, 64'hD10);
        step();
        chk("sat_hold", pass_cnt, 4'd15);

        // clear wins over a simultaneous tlast
        beat(64'h99, 1'b1, 1'b0, 10'h005, 8'hFF);
        clear = 1'b1;
        step();
        clear     = 1'b0;
        in_tvalid = 1'b0;
        chk("clr_pass", pass_cnt, 4'd0);
        chk("clr_drop", drop_cnt, 4'd0);
        beat(64'h9A, 1'b1, 1'b1, 10'h005, 8'hFF);
        step();
        in_tvalid = 1'b0;
        chk("clr_after_drop", drop_cnt, 4'd1);
        chk("clr_after_pass", pass_cnt, 4'd0);
        step();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/parse_drop_filter.md
PARSE_DROP_FILTER -- requirements
Module: parse_drop_filter

Interface
REQ-001 Parameters SHALL be: AXIS_BUS_WIDTH, default 64, stream data width in bits; SIDE_CHAN_WIDTH, default 10, side-channel data width; CNT_WIDTH, default 32, statistics counter width; NUM_BUS_BYTES, derived as AXIS_BUS_WIDTH/8.
REQ-002 Ports SHALL be, one per line, name direction width meaning:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  synchronous, active-low reset.
- axis_in_tdata  in  AXIS_BUS_WIDTH  input beat data.
- axis_in_tkeep  in  NUM_BUS_BYTES  input byte enables.
- axis_in_tlast  in  1  input end of packet.
- axis_in_tvalid  in  1  input beat valid.
- axis_in_tready  out  1  input beat accepted.
- chan_in_data  in  SIDE_CHAN_WIDTH  per-packet parse result; valid with every beat of its packet.
- chan_in_error  in  1  per-packet drop flag; valid with every beat of its packet.
- axis_out_tdata  out  AXIS_BUS_WIDTH  forwarded data.
- axis_out_tkeep  out  NUM_BUS_BYTES  forwarded byte enables.
- axis_out_tlast  out  1  forwarded end of packet.
- axis_out_tuser  out  SIDE_CHAN_WIDTH  side data of the packet, constant on every beat.
- axis_out_tvalid  out  1  output beat valid.
- axis_out_tready  in  1  downstream ready.
- clear_counts  in  1  single-cycle synchronous counter clear.
- pass_count  out  CNT_WIDTH  packets forwarded.
- drop_count  out  CNT_WIDTH  packets dropped.

Function
REQ-003 The FSM SHALL have states SOP (next beat is first of a packet), PASS, and DROP.
REQ-004 In SOP, an accepted beat with chan_in_error=1 SHALL be discarded, SHALL move the FSM to DROP, and SHALL return it to SOP if tlast=1.
REQ-005 In SOP, an accepted beat with chan_in_error=0 SHALL be forwarded, SHALL latch chan_in_data into a tuser register, and SHALL move the FSM to PASS, or keep it in SOP if tlast=1.
REQ-006 The block SHALL sample chan_in_data and chan_in_error only on the SOP beat, and SHALL ignore changes on later beats of the same packet.
REQ-007 In PASS, every accepted beat SHALL be forwarded with the latched tuser, and an accepted tlast SHALL return the FSM to SOP.
REQ-008 In DROP, axis_in_tready SHALL be 1, every beat SHALL be discarded with no output, and an accepted tlast SHALL return the FSM to SOP.
REQ-009 Forwarded beats SHALL pass through a two-register skid stage (main and skid), with axis_in_tready in SOP/PASS = NOT skid_valid, a registered signal that does not depend on the tvalid/tready inputs in the same cycle.
REQ-010 The latency from accepted input beat to axis_out_tvalid SHALL be 1 cycle when the output is unstalled, and sustained throughput SHALL be 1 beat/cycle while axis_out_tready=1.
REQ-011 Once axis_out_tvalid=1, axis_out_* SHALL hold stable until axis_out_tready=1, and no beat SHALL be lost or duplicated under any back-pressure pattern.
REQ-012 When the main register is full and downstream stalls, a newly accepted beat SHALL go to the skid register; when downstream accepts, skid SHALL move to main in the same cycle.
REQ-013 pass_count SHALL increment by 1 when a forwarded tlast beat is accepted at the input.
REQ-014 drop_count SHALL increment by 1 when a discarded tlast beat is accepted at the input.
REQ-015 Both counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-016 clear_counts SHALL zero both counters on the next edge, and clear SHALL win over a simultaneous increment.
REQ-017 An SOP beat with tlast=1 SHALL count as a complete packet of one beat.
REQ-018 The block SHALL apply no tkeep qualification, so a tkeep=0 beat is treated as a normal beat.

Reset
REQ-019 While aresetn=0: FSM=SOP, main and skid registers invalid, axis_out_tvalid=0, axis_in_tready=0, pass_count=0, drop_count=0, tuser register=0.
REQ-020 On the first cycle after reset deassertion, axis_in_tready SHALL be 1.
REQ-021 Reset mid-packet SHALL discard buffered beats, and the next accepted beat SHALL be treated as SOP.

Verification
REQ-022 3-beat packet, error=0, chan_data=0x155, out_tready=1 -> 3 beats out, 1-cycle latency, tuser=0x155 on all, tlast on beat 3, pass_count=1.
REQ-023 2-beat packet error=1, then 1-beat packet error=0 with chan_data=0x0A0 -> only the 1-beat packet is output with tuser=0x0A0, drop_count=1, pass_count=1.
REQ-024 Continuous input with out_tready toggling 1/0 each cycle across 20 beats -> output sequence equals input sequence, no loss or duplication, and in_tready falls only while skid_valid=1.
REQ-025 chan_in_error changes 0->1 on beat 2 of a 4-beat packet -> all 4 beats forwarded, tuser unchanged, pass_count=1.
REQ-026 CNT_WIDTH=4, 17 passed packets -> pass_count=15; then clear_counts asserted in the same cycle as a tlast -> pass_count=0.
REQ-027 aresetn pulsed low during beat 2 of a PASS packet -> axis_out_tvalid=0 the next cycle, and the following beat is handled as SOP with its own chan_in_error.
